rca_slice_seq_adder: RTL and testbench
======================================

Name: rca_slice_seq_adder

Overview:
- Multi-cycle wide adder built around one narrow ripple-carry slice adder (rcax, width=SLICE).
- Adds two WIDTH-bit operands plus carry-in over WIDTH/SLICE cycles, least-significant slice first. The inter-slice carry is registered, so the critical path is one SLICE-bit ripple.
- Valid/ready on both sides. Used where a full WIDTH-bit ripple chain misses timing and throughput is not critical, e.g. the final accumulate in multiplier datapaths.

Parameters:
- WIDTH, 16: operand and sum width in bits.
- SLICE, 4: bits added per cycle; width of the single rcax instance. WIDTH must be an integer multiple of SLICE; N = WIDTH/SLICE >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  addend A.
- b  input  WIDTH  addend B.
- c_i  input  1  carry-in to bit 0.
- out_valid  output  1  sum/c_o valid.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  (a + b + c_i) mod 2^WIDTH.
- c_o  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in RUN or DONE.

Behaviour:
- One clock domain. Reset is asynchronous and active-low: assertion of rst_n=0 immediately clears all state; release is on a clk edge.
- Reset values:
  - State=IDLE; in_ready=1; out_valid=0; busy=0.
  - sum=0; c_o=0.
  - Internal operand shift registers, carry register and slice counter = 0.
- FSM states: IDLE, RUN, DONE. in_ready = (state==IDLE); out_valid = (state==DONE); busy = !in_ready.
- IDLE:
  - On in_valid & in_ready: latch a, b into shift registers and c_i into the carry register; counter=0; go to RUN.
  - in_valid without acceptance has no effect.
- RUN, one slice per cycle:
  - rcax adds the low SLICE bits of both shift registers with the carry register.
  - The slice sum is shifted into sum from the MSB end; sum shifts right by SLICE.
  - The slice carry-out is written to the carry register.
  - Operand registers shift right by SLICE; counter increments.
  - When counter==N-1 at the clock edge, the final slice is written, c_o takes the final carry, and the state goes to DONE.
- Latency:
  - out_valid rises exactly N clock edges after the accepting edge.
  - N=1 (SLICE==WIDTH) gives a single RUN cycle.
- DONE:
  - sum and c_o are held stable while out_valid=1 and out_ready=0, for any duration.
  - On out_ready=1: go to IDLE; in_ready=1 the next cycle.
  - No accept in the same cycle as result handoff. Minimum initiation interval is N+2 cycles.
- sum/c_o persist after handoff until the next operation's RUN cycles overwrite sum. Consumers must qualify with out_valid.
- out_ready is ignored outside DONE. Inputs a/b/c_i are ignored outside the accepting cycle; changing them during RUN does not affect the result.
- Reset mid-operation (RUN or DONE):
  - Operation is aborted and all outputs return to reset values.
  - No out_valid is produced for the aborted operation.
- Arithmetic is unsigned modular. Signed (two's-complement) callers interpret sum directly; overflow detection is the caller's job.
- Counter width: clog2(N), minimum 1 bit; it must not wrap before N-1 is reached.

Test Plan (WIDTH=16, SLICE=4 unless noted):
- Carry ripple across all slices: a=0xFFFF, b=0x0001, c_i=0 -> sum=0x0000, c_o=1; out_valid exactly 4 edges after accept; in_ready=0 throughout.
- Carry-in with no carry-out: a=0x1234, b=0x4321, c_i=1 -> sum=0x5556, c_o=0.
- Backpressure: a=0x8000, b=0x8000, c_i=0; hold out_ready=0 for 6 cycles after out_valid -> sum=0x0000, c_o=1 stable all 6 cycles. Raise out_ready -> out_valid=0 and in_ready=1 next cycle.
- Reset mid-operation:
  - Accept a=0x00FF, b=0x0F0F; pulse rst_n low asynchronously (between edges) after the 2nd RUN edge -> outputs clear immediately, no out_valid.
  - After release, a=0x0001, b=0x0002, c_i=0 -> sum=0x0003, c_o=0.
- Degenerate and alternate configurations:
  - WIDTH=16, SLICE=16: a=0xFFFF, b=0xFFFF, c_i=1 -> sum=0xFFFF, c_o=1, out_valid 1 edge after accept.
  - WIDTH=8, SLICE=1: a=0x7F, b=0x01, c_i=0 -> sum=0x80, c_o=0 after 8 edges.
- Randomized back-to-back: 1000 random a/b/c_i with random in_valid/out_ready gaps -> every result equals {c_o,sum} = a+b+c_i from a reference model; no lost or duplicated transactions.

Source files
------------

// File: rtl/rca_slice_seq_adder.sv
// rtl/rca_slice_seq_adder.sv - multi-cycle WIDTH-bit adder built from one SLICE-bit ripple slice
// Slices are added LSB first; the inter-slice carry is registered so only one SLICE ripple is timed.

module rcax #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[W];
endmodule

module rca_slice_seq_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_o,
  output logic             busy
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  logic [WIDTH-1:0]       a_q;
  logic [WIDTH-1:0]       b_q;
  logic                   carry_q;
  logic [CW-1:0]          cnt;
  logic [SLICE-1:0]       slice_sum;
  logic                   slice_co;
  logic [WIDTH+SLICE-1:0] sum_cat;

  rcax #(.W(SLICE)) u_rcax (
    .a  (a_q[SLICE-1:0]),
    .b  (b_q[SLICE-1:0]),
    .ci (carry_q),
    .s  (slice_sum),
    .co (slice_co)
  );

  // New slice enters at the MSB end; works unchanged when SLICE == WIDTH.
  assign sum_cat = {slice_sum, sum};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      c_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= c_i;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum     <= sum_cat[WIDTH+SLICE-1:SLICE];
          carry_q <= slice_co;
          a_q     <= a_q >> SLICE;
          b_q     <= b_q >> SLICE;
          cnt     <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            c_o   <= slice_co;
            cnt   <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = !in_ready;
endmodule

// File: tb/tb_rca_slice_seq_adder.sv
// tb/tb_rca_slice_seq_adder.sv - randomized and directed bench for rca_slice_seq_adder
// Main instance 16/4 is tracked cycle by cycle by an edge-countdown model; 16/16 and 8/1 get directed runs.

module tb_rca_slice_seq_adder;
  localparam int W = 16;
  localparam int S = 4;
  localparam int N = W / S;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, c_i = 1'b0, out_ready = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, c_o, busy;
  logic [W-1:0] sum;

  logic        w_in_valid = 1'b0, w_c_i = 1'b0, w_out_ready = 1'b0;
  logic [15:0] w_a = '0, w_b = '0, w_sum;
  logic        w_in_ready, w_out_valid, w_c_o, w_busy;

  logic        n_in_valid = 1'b0, n_c_i = 1'b0, n_out_ready = 1'b0;
  logic [7:0]  n_a = '0, n_b = '0, n_sum;
  logic        n_in_ready, n_out_valid, n_c_o, n_busy;

  rca_slice_seq_adder #(.WIDTH(W), .SLICE(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_i(c_i), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_o(c_o), .busy(busy)
  );

  rca_slice_seq_adder #(.WIDTH(16), .SLICE(16)) dut_wide (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .c_i(w_c_i), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .sum(w_sum), .c_o(w_c_o), .busy(w_busy)
  );

  rca_slice_seq_adder #(.WIDTH(8), .SLICE(1)) dut_bit (
    .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .a(n_a), .b(n_b), .c_i(n_c_i), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .sum(n_sum), .c_o(n_c_o), .busy(n_busy)
  );

  int n_checks = 0;
  int n_pass = 0;
  int dut_handoffs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Model: 0 = idle, 1 = counting N edges after accept, 2 = result held for consumer.
  int       m_phase = 0;
  int       m_left = 0;
  logic [W:0] m_exp = '0;
  bit       m_zero = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_left  = 0;
      m_zero  = 1'b1;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_exp   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_i};
          m_left  = N;
          m_phase = 1;
          m_zero  = 1'b0;
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    check("in_ready", in_ready, m_phase == 0);
    check("out_valid", out_valid, m_phase == 2);
    check("busy", busy, m_phase != 0);
    if (m_phase == 2) check("result", {c_o, sum}, m_exp);
    if (m_zero) begin
      check("sum_reset", sum, 0);
      check("c_o_reset", c_o, 0);
    end
    if (rst_n && out_valid && out_ready) dut_handoffs++;
  end

  task automatic do_op(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                       input int hold, output logic [16:0] res, output int lat);
    int t;
    t = 0;
    while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
    a = xa; b = xb; c_i = xc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); c_i = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      check("in_ready_run", in_ready, 0);
      @(posedge clk); #1; lat++;
    end
    res = {c_o, sum};
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_result", {c_o, sum}, res);
      check("hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ready_after", in_ready, 1);
    check("valid_after", out_valid, 0);
  endtask

  initial begin
    logic [16:0] res;
    int lat, t, base, n_sent;
    bit accepted, rand_done;

    repeat (3) @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(16'hFFFF, 16'h0001, 1'b0, 0, res, lat);
    check("ripple_res", res, 17'h10000);
    check("ripple_lat", lat, 4);
    do_op(16'h1234, 16'h4321, 1'b1, 0, res, lat);
    check("cin_res", res, 17'h05556);
    do_op(16'h8000, 16'h8000, 1'b0, 6, res, lat);
    check("bp_res", res, 17'h10000);

    a = 16'h00FF; b = 16'h0F0F; c_i = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_sum", sum, 0);
    check("abort_c_o", c_o, 0);
    #3 rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; check("no_valid_after_abort", out_valid, 0); end
    do_op(16'h0001, 16'h0002, 1'b0, 0, res, lat);
    check("post_rst_res", res, 17'h00003);

    check("wide_ready", w_in_ready, 1);
    w_a = 16'hFFFF; w_b = 16'hFFFF; w_c_i = 1'b1; w_in_valid = 1'b1;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    lat = 0;
    while (!w_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("wide_lat", lat, 1);
    check("wide_res", {w_c_o, w_sum}, 17'h1FFFF);
    w_out_ready = 1'b1;
    @(posedge clk); #1;
    w_out_ready = 1'b0;
    check("wide_ready_after", w_in_ready, 1);

    check("bit_ready", n_in_ready, 1);
    n_a = 8'h7F; n_b = 8'h01; n_c_i = 1'b0; n_in_valid = 1'b1;
    @(posedge clk); #1;
    n_in_valid = 1'b0;
    lat = 0;
    while (!n_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("bit_lat", lat, 8);
    check("bit_res", {n_c_o, n_sum}, 9'h080);
    n_out_ready = 1'b1;
    @(posedge clk); #1;
    n_out_ready = 1'b0;

    base = dut_handoffs;
    n_sent = 0;
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
            a = 16'($urandom); b = 16'($urandom); c_i = 1'($urandom);
          end
          a = 16'($urandom); b = 16'($urandom); c_i = 1'($urandom);
          in_valid = 1'b1;
          accepted = 1'b0;
          t = 0;
          while (!accepted && t < 200) begin
            @(negedge clk);
            if (in_ready) accepted = 1'b1;
            @(posedge clk); #1;
            t++;
          end
          if (!accepted) check("accept_timeout", 0, 1);
          in_valid = 1'b0;
          n_sent++;
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    t = 0;
    while (busy && t < 50) begin @(posedge clk); #1; t++; end
    out_ready = 1'b0;
    check("drain_idle", busy, 0);
    check("handoff_count", dut_handoffs - base, 1000);
    check("sent_count", n_sent, 1000);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
